// File: rtl/router_egress_arbiter.sv
// Round-robin, packet-atomic egress scheduler for three router FIFOs with a 2-entry skid buffer.
// Optional ROUTER_EGRESS_PARITY_CHK_EN adds a parity_err output checking each packet's parity byte.
module router_egress_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RR_INIT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vld_out_0,
  input  logic              vld_out_1,
  input  logic              vld_out_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_out_2,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic [DATA_W-1:0] egress_data,
  output logic              egress_valid,
  input  logic              egress_ready,
  output logic              egress_sop,
  output logic              egress_eop,
  output logic              pkt_abort,
  output logic [2:0]        grant,
`ifdef ROUTER_EGRESS_PARITY_CHK_EN
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int unsigned CntW = DATA_W - 1;

  typedef enum logic [2:0] {StIdle, StHdr, StHwait, StXfer, StDone} state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic [2:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [CntW-1:0]   rd_left_q, rd_left_d;
  logic              inflight_q, inflight_d;
  logic              infl_sop_q, infl_sop_d;
  logic              infl_eop_q, infl_eop_d;
  logic              abort_q, abort_d;
  entry_t            head_q, head_d, tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  logic [2:0]        req;
  logic              vld_g, srst_g;
  logic [DATA_W-1:0] data_g;
  logic [1:0]        pick;
  logic [2:0]        occ;
  logic              pop, push, credit, abort, rd_fire, eop_hs;
  logic [1:0]        wr_idx;
  entry_t            new_entry;

  assign req = {vld_out_2 & ~soft_reset_2, vld_out_1 & ~soft_reset_1, vld_out_0 & ~soft_reset_0};

  always_comb begin
    vld_g  = vld_out_0;
    srst_g = soft_reset_0;
    data_g = data_out_0;
    case (gnt_idx_q)
      2'd1: begin vld_g = vld_out_1; srst_g = soft_reset_1; data_g = data_out_1; end
      2'd2: begin vld_g = vld_out_2; srst_g = soft_reset_2; data_g = data_out_2; end
      default: ;
    endcase
  end

  always_comb begin
    case (last_q)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Occupancy counts the byte still returning from the FIFO so the buffer can never overflow.
  assign pop    = (count_q != 2'd0) & egress_ready;
  assign occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit = occ < 3'd2;
  assign abort  = (state_q != StIdle) & srst_g;
  assign push   = inflight_q & ~abort;
  assign eop_hs = pop & head_q.eop;

  always_comb begin
    rd_fire = 1'b0;
    if (state_q == StHdr)  rd_fire = vld_g & credit;
    if (state_q == StXfer) rd_fire = vld_g & credit & (rd_left_q != '0);
    rd_fire = rd_fire & ~abort;
  end

  assign read_enb_0 = rd_fire & (gnt_idx_q == 2'd0);
  assign read_enb_1 = rd_fire & (gnt_idx_q == 2'd1);
  assign read_enb_2 = rd_fire & (gnt_idx_q == 2'd2);

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rd_left_d  = rd_left_q;
    inflight_d = rd_fire;
    infl_sop_d = (state_q == StHdr);
    infl_eop_d = (state_q == StXfer) && (rd_left_q == CntW'(1));
    abort_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d   = 3'b001 << pick;
          gnt_idx_d = pick;
          last_d    = pick;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (rd_fire) state_d = StHwait;
      end
      StHwait: begin
        // Payload length plus the trailing parity byte.
        rd_left_d = {1'b0, data_g[DATA_W-1:2]} + CntW'(1);
        state_d   = StXfer;
      end
      StXfer: begin
        if (rd_fire) rd_left_d = rd_left_q - CntW'(1);
        if ((rd_left_q == '0) && eop_hs) state_d = StDone;
      end
      StDone: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d    = StIdle;
      grant_d    = 3'b000;
      abort_d    = 1'b1;
      inflight_d = 1'b0;
      rd_left_d  = '0;
    end
  end

  assign new_entry = {infl_sop_q, infl_eop_q, data_g};
  assign wr_idx    = count_q - {1'b0, pop};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (abort) begin
      count_d = 2'd0;
    end else begin
      if (pop) head_d = tail_q;
      if (push) begin
        if (wr_idx == 2'd0) head_d = new_entry;
        else                tail_d = new_entry;
      end
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

`ifdef ROUTER_EGRESS_PARITY_CHK_EN
  logic [DATA_W-1:0] par_acc_q, par_acc_d;

  always_comb begin
    par_acc_d = par_acc_q;
    if (abort) begin
      par_acc_d = '0;
    end else if (push) begin
      if (infl_sop_q)       par_acc_d = data_g;
      else if (!infl_eop_q) par_acc_d = par_acc_q ^ data_g;
    end
  end

  // No push can follow the eop byte before the next header, so the accumulator is stable here.
  assign parity_err = eop_hs & (head_q.data != par_acc_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) par_acc_q <= '0;
    else         par_acc_q <= par_acc_d;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      gnt_idx_q  <= 2'd0;
      grant_q    <= 3'b000;
      last_q     <= 2'(RR_INIT);
      rd_left_q  <= '0;
      inflight_q <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      abort_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      rd_left_q  <= rd_left_d;
      inflight_q <= inflight_d;
      infl_sop_q <= infl_sop_d;
      infl_eop_q <= infl_eop_d;
      abort_q    <= abort_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign egress_valid = (count_q != 2'd0);
  assign egress_data  = head_q.data;
  assign egress_sop   = egress_valid & head_q.sop;
  assign egress_eop   = egress_valid & head_q.eop;
  assign pkt_abort    = abort_q;
  assign grant        = grant_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: FIFO models feed packets, egress stream is scoreboarded.
module tb_router_egress_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] egress_data;
  logic       egress_valid, egress_ready, egress_sop, egress_eop, pkt_abort, busy;
  logic [2:0] grant;
`ifdef ROUTER_EGRESS_PARITY_CHK_EN
  logic       parity_err;
`endif

  router_egress_arbiter #(.DATA_W(8), .RR_INIT(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .data_out_0   (data_out_0),
    .data_out_1   (data_out_1),
    .data_out_2   (data_out_2),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .egress_data  (egress_data),
    .egress_valid (egress_valid),
    .egress_ready (egress_ready),
    .egress_sop   (egress_sop),
    .egress_eop   (egress_eop),
    .pkt_abort    (pkt_abort),
    .grant        (grant),
`ifdef ROUTER_EGRESS_PARITY_CHK_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] hdr;
    int         stall_at;
    int         stall_len;
    logic [2:0] exp_gnt;
    int         exp_reads;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] fq0[$], fq1[$], fq2[$], exp_q[$];
  int         n_chk, n_pass, cyc;
  logic [2:0] s_grant, s_re;
  logic       s_valid, s_ready, s_sop, s_eop, s_abort, s_busy, s_perr;
  logic [7:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic upd_vld();
    vld_out_0 = (fq0.size() != 0);
    vld_out_1 = (fq1.size() != 0);
    vld_out_2 = (fq2.size() != 0);
  endtask

  task automatic push_byte(input int ch, input logic [7:0] b);
    case (ch)
      0:       fq0.push_back(b);
      1:       fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
    exp_q.push_back(b);
  endtask

  task automatic load_packet(input int ch, input logic [7:0] hdr, input bit corrupt);
    logic [7:0] par, b;
    int len;
    len = int'(hdr[7:2]);
    par = hdr;
    push_byte(ch, hdr);
    for (int i = 0; i < len; i++) begin
      b = hdr ^ 8'(i * 37 + 5);
      par = par ^ b;
      push_byte(ch, b);
    end
    if (corrupt) par = par ^ 8'h01;
    push_byte(ch, par);
    upd_vld();
  endtask

  // Sample outputs mid-cycle, then model the FIFOs' registered read data after the edge.
  task automatic step();
    @(negedge clk);
    s_grant = grant;
    s_re    = {read_enb_2, read_enb_1, read_enb_0};
    s_valid = egress_valid;
    s_ready = egress_ready;
    s_data  = egress_data;
    s_sop   = egress_sop;
    s_eop   = egress_eop;
    s_abort = pkt_abort;
    s_busy  = busy;
    s_perr  = 1'b0;
`ifdef ROUTER_EGRESS_PARITY_CHK_EN
    s_perr  = parity_err;
`endif
    cyc++;
    @(posedge clk);
    #1;
    if (s_re[0] && fq0.size() != 0) data_out_0 = fq0.pop_front();
    if (s_re[1] && fq1.size() != 0) data_out_1 = fq1.pop_front();
    if (s_re[2] && fq2.size() != 0) data_out_2 = fq2.pop_front();
    upd_vld();
  endtask

  task automatic drain(input string tag, output int pe_cnt, output int pe_eop);
    int nb, n;
    bit done;
    nb = 0; n = exp_q.size(); done = 0; pe_cnt = 0; pe_eop = 0;
    for (int k = 0; k < 150 && !done; k++) begin
      step();
      if (s_perr) begin
        pe_cnt++;
        if (s_valid && s_ready && s_eop) pe_eop++;
      end
      if (s_valid && s_ready) begin
        if (nb < n) begin
          check({tag, " data"}, s_data, exp_q[nb]);
          check({tag, " sop"}, s_sop, nb == 0);
          check({tag, " eop"}, s_eop, nb == n - 1);
        end
        nb++;
      end
      if (nb >= n && !s_busy) done = 1;
    end
    check({tag, " complete"}, done, 1);
    check({tag, " byte count"}, nb, n);
  endtask

  int         nb, nrd, f_rd, l_rd, f_g, f_v, outst, max_out, gi, hs, pe, pq;
  bit         done, pstall, direct;
  logic [2:0] g_val, prev, gseq[4];
  logic [7:0] p_data;
  logic [2:0] p_flags;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    resetn = 1'b0; egress_ready = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    data_out_0 = '0; data_out_1 = '0; data_out_2 = '0;
    vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;

    vecs[0] = '{ch: 1, hdr: 8'h0D, stall_at: 0, stall_len: 0, exp_gnt: 3'b010, exp_reads: 5};
    vecs[1] = '{ch: 0, hdr: 8'h20, stall_at: 6, stall_len: 4, exp_gnt: 3'b001, exp_reads: 10};
    vecs[2] = '{ch: 2, hdr: 8'h02, stall_at: 0, stall_len: 0, exp_gnt: 3'b100, exp_reads: 2};
    vecs[3] = '{ch: 1, hdr: 8'h09, stall_at: 3, stall_len: 2, exp_gnt: 3'b010, exp_reads: 4};

    // All three FIFOs hold len-1 packets from reset; ch0 holds two.
    exp_q.delete();
    load_packet(0, 8'h04, 0);
    load_packet(1, 8'h05, 0);
    load_packet(2, 8'h06, 0);
    load_packet(0, 8'h07, 0);
    #3;
    check("rst grant", grant, 3'b000);
    check("rst read_enb", {read_enb_2, read_enb_1, read_enb_0}, 3'b000);
    check("rst egress_valid", egress_valid, 0);
    check("rst sop/eop", {egress_sop, egress_eop}, 2'b00);
    check("rst egress_data", egress_data, 8'h00);
    check("rst pkt_abort", pkt_abort, 0);
    check("rst busy", busy, 0);
    #9 resetn = 1'b1;

    prev = 3'b000; direct = 0; gi = 0; nb = 0;
    for (int k = 0; k < 200 && !(nb == 12 && !s_busy); k++) begin
      step();
      if (s_grant != 3'b000 && s_grant != prev) begin
        if (prev != 3'b000) direct = 1;
        if (gi < 4) gseq[gi] = s_grant;
        gi++;
      end
      prev = s_grant;
      if (s_valid && s_ready) begin
        if (nb < exp_q.size()) check("rr data", s_data, exp_q[nb]);
        nb++;
      end
    end
    check("rr grant count", gi, 4);
    check("rr grant 0", gseq[0], 3'b001);
    check("rr grant 1", gseq[1], 3'b010);
    check("rr grant 2", gseq[2], 3'b100);
    check("rr grant 3", gseq[3], 3'b001);
    check("rr idle gap", direct, 0);
    check("rr bytes", nb, 12);

    for (int v = 0; v < 4; v++) begin
      exp_q.delete();
      load_packet(vecs[v].ch, vecs[v].hdr, 0);
      nb = 0; nrd = 0; f_rd = -1; l_rd = -1; f_g = -1; f_v = -1; g_val = 3'b000;
      outst = 0; max_out = 0; done = 0; pstall = 0; p_data = '0; p_flags = '0;
      for (int k = 0; k < 120 && !done; k++) begin
        egress_ready = !(k >= vecs[v].stall_at && k < vecs[v].stall_at + vecs[v].stall_len);
        step();
        if (pstall) begin
          check($sformatf("v%0d hold data", v), s_data, p_data);
          check($sformatf("v%0d hold flags", v), {s_valid, s_sop, s_eop}, p_flags);
        end
        pstall  = s_valid && !s_ready;
        p_data  = s_data;
        p_flags = {1'b1, s_sop, s_eop};
        if (s_grant != 3'b000 && f_g < 0) begin f_g = k; g_val = s_grant; end
        if (s_re != 3'b000) begin
          nrd++; outst++; l_rd = k;
          if (f_rd < 0) f_rd = k;
        end
        if (s_valid && f_v < 0) f_v = k;
        if (s_valid && s_ready) begin
          if (nb < exp_q.size()) begin
            check($sformatf("v%0d data", v), s_data, exp_q[nb]);
            check($sformatf("v%0d sop", v), s_sop, nb == 0);
            check($sformatf("v%0d eop", v), s_eop, nb == exp_q.size() - 1);
          end
          nb++; outst--;
        end
        if (outst > max_out) max_out = outst;
        if (nb >= exp_q.size() && !s_busy) done = 1;
      end
      check($sformatf("v%0d complete", v), done, 1);
      check($sformatf("v%0d grant", v), g_val, vecs[v].exp_gnt);
      check($sformatf("v%0d grant latency", v), f_g, 1);
      check($sformatf("v%0d read latency", v), f_rd, 1);
      check($sformatf("v%0d egress latency", v), f_v, 3);
      check($sformatf("v%0d reads", v), nrd, vecs[v].exp_reads);
      check($sformatf("v%0d bytes", v), nb, vecs[v].exp_reads);
      check($sformatf("v%0d outstanding<=2", v), max_out <= 2, 1);
      if (vecs[v].stall_len == 0)
        check($sformatf("v%0d read span", v), l_rd - f_rd, vecs[v].exp_reads);
    end
    egress_ready = 1'b1;

    // Abort of a granted ch2 packet while ch0 waits.
    exp_q.delete();
    load_packet(2, 8'h18, 0);
    for (int k = 0; k < 10 && s_grant != 3'b100; k++) step();
    check("abort setup grant", s_grant, 3'b100);
    exp_q.delete();
    load_packet(0, 8'h08, 0);
    hs = 0;
    for (int k = 0; k < 40 && hs < 3; k++) begin
      step();
      if (s_valid && s_ready) hs++;
    end
    check("abort setup bytes", hs, 3);
    soft_reset_2 = 1'b1;
    step();
    check("abort read_enb_2 gated", s_re[2], 0);
    soft_reset_2 = 1'b0;
    fq2.delete();
    upd_vld();
    step();
    check("abort pulse", s_abort, 1);
    check("abort egress flushed", s_valid, 0);
    check("abort grant cleared", s_grant, 3'b000);
    step();
    check("abort pulse single", s_abort, 0);
    check("abort regrant ch0", s_grant, 3'b001);
    drain("post-abort", pe, pq);

    // Asynchronous reset in the middle of a ch1 packet.
    exp_q.delete();
    load_packet(1, 8'h10, 0);
    for (int k = 0; k < 6; k++) step();
    #2 resetn = 1'b0;
    #1;
    check("async rst grant", grant, 3'b000);
    check("async rst busy", busy, 0);
    check("async rst valid", egress_valid, 0);
    check("async rst read_enb", {read_enb_2, read_enb_1, read_enb_0}, 3'b000);
    fq1.delete();
    data_out_1 = '0;
    upd_vld();
    #3 resetn = 1'b1;
    exp_q.delete();
    load_packet(1, 8'h0C, 0);
    drain("post-reset", pe, pq);

`ifdef ROUTER_EGRESS_PARITY_CHK_EN
    exp_q.delete();
    load_packet(0, 8'h0C, 1);
    drain("bad parity", pe, pq);
    check("bad parity pulses", pe, 1);
    check("bad parity on eop", pq, 1);
    exp_q.delete();
    load_packet(2, 8'h14, 0);
    drain("good parity", pe, pq);
    check("good parity pulses", pe, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_egress_arbiter.md
Name: router_egress_arbiter

Overview:
- Round-robin, packet-atomic scheduler that shares a single egress port among the router's three output FIFOs.
- Drives read_enb_0..2, consumes vld_out_x and soft_reset_x from the sync block, and parses each packet header for its length.
- Emits framed bytes (sop/eop) through a 2-entry skid buffer under valid/ready backpressure.
- Sits between the three FIFOs and the downstream serializer/DMA.

Parameters:
- DATA_W, 8, byte width. The header is {len[DATA_W-1:2], addr[1:0]}.
- RR_INIT, 2, initial last-grant index, so channel 0 wins the first arbitration.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- vld_out_0/1/2  in  1  FIFO x non-empty
- soft_reset_0/1/2  in  1  FIFO x being flushed
- data_out_0/1/2  in  DATA_W  FIFO x read data, valid the cycle after read_enb_x
- read_enb_0/1/2  out  1  FIFO x pop, combinational from state
- egress_data  out  DATA_W  head of skid buffer
- egress_valid  out  1  buffer non-empty
- egress_ready  in  1  downstream accept
- egress_sop  out  1  egress_data is a header byte
- egress_eop  out  1  egress_data is a parity byte
- pkt_abort  out  1  one-cycle pulse, granted packet aborted
- grant  out  3  one-hot current owner, 000 when idle
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=RR_INIT, skid buffer empty, in-flight flag 0, rd_left 0.
- Request for channel x: req_x = vld_out_x & ~soft_reset_x.
- IDLE:
  - If any req, grant the first requester searching last_grant+1, +2, +3 (mod 3).
  - grant and last_grant are registered; next state is HDR.
- HDR: read_enb_g = vld_out_g & credit. Once that pop fires, next state is HWAIT.
- HWAIT: the header is on data_out_g. It is pushed to the buffer with the sop tag. rd_left <= len+1 (payload plus parity). Next state is XFER. This costs one bubble per packet.
- XFER:
  - read_enb_g = vld_out_g & credit & (rd_left != 0). Each pop decrements rd_left.
  - The returned byte is pushed next cycle. It carries the eop tag when it is the read issued with rd_left==1.
  - An empty FIFO mid-packet simply stalls; there is no timeout.
- DONE:
  - Entered when rd_left==0 and the eop-tagged byte's egress handshake fires.
  - grant clears and state returns to IDLE; arbitration happens the following cycle.
- Credit rule: (buf_count + inflight - pop_this_cycle) < 2, where pop_this_cycle = egress_valid & egress_ready. This sustains one byte/cycle with egress_ready=1 and never overflows the 2-entry buffer.
- Latency, vld_out_0 rising in cycle t while idle: grant=001 at t+1, read_enb_0 at t+1, egress_valid with the header at t+3.
- Egress: data, sop and eop are stable while egress_valid & ~egress_ready. Bytes are never dropped or duplicated.
- Length 0: rd_left=1, so a 2-byte packet. sop and eop appear on consecutive egress bytes.
- Abort: soft_reset_g high in any non-IDLE state. In that same cycle:
  - read_enb_g=0 combinationally.
  - In-flight data is discarded.
  - The skid buffer is flushed, so egress_valid is 0 next cycle.
  - pkt_abort pulses next cycle, grant clears, and state goes to IDLE.
- Non-granted soft_reset: affects only req_x.
- Simultaneous eop completion and a new request: the new grant is issued no earlier than the cycle after DONE.
- Asynchronous reset mid-packet: immediate return to reset values. A partial packet is lost with no eop.

Optional Feature:
- Macro: ROUTER_EGRESS_PARITY_CHK_EN.
- Defined:
  - Adds output port parity_err (1 bit, reset 0).
  - A running XOR over the header and payload is compared with the parity byte.
  - parity_err is high only in the cycle the eop byte handshakes, and only on mismatch.
  - The accumulator clears at sop and on abort.
- Undefined: no port, no logic.

Test Plan:
- Ch1 packet header 0x0D (len 3), egress_ready=1:
  - grant=010 and 5 read_enb_1 pulses.
  - Egress bytes 0x0D, p0, p1, p2, par; sop on the first byte, eop on the last.
  - Reads back-to-back after the single HWAIT bubble.
- vld_out_0/1/2 all high from reset, each with a len-1 packet, repeated: grant order 001, 010, 100, 001; at least one IDLE cycle between packets.
- egress_ready low for 4 cycles mid-payload (len 8):
  - read_enb stops with buf_count+inflight ≤ 2.
  - All 10 bytes delivered in order, none duplicated.
- Len-0 packet on ch2 (header 0x02): exactly 2 reads and 2 egress bytes; sop and eop on consecutive beats.
- soft_reset_2 asserted after 3 bytes of a len-6 packet with vld_out_0 pending:
  - read_enb_2=0 that cycle.
  - pkt_abort pulse next cycle with egress_valid=0.
  - grant=001 two cycles after the abort.
- With the macro defined, packet with a corrupted parity byte: parity_err=1 exactly on the eop beat. A correct-parity packet gives parity_err=0 throughout.
